// File: rtl/vga_pixel_stage.sv
// rtl/vga_pixel_stage.sv - VGA pixel stage: framebuffer/palette or test pattern to registered RGB
//
// Purpose
//   Sits after the hvsync generator. Produces a registered 12-bit RGB pixel plus
//   hsync/vsync/DE delayed to line up with it. Pixels come either from a
//   downscaled framebuffer (external sync RAM, one-cycle read) through a 16-entry
//   palette, or from one of three built-in test patterns. The display mode is
//   latched only at frame boundaries, where a frame counter also advances.
//
// Ports
//   clk_i            pixel clock
//   reset_ni         asynchronous reset, active low
//   hpos_i/vpos_i    beam position from the sync generator
//   display_on_i     visible-area flag from the sync generator
//   hsync_in_i       hsync from the sync generator
//   vsync_in_i       vsync from the sync generator
//   mode_i           0 framebuffer, 1 colour bars, 2 checkerboard, 3 border
//   fb_rd_en_o       framebuffer read enable
//   fb_addr_o        framebuffer read address {row, column}
//   fb_data_i        framebuffer data, valid the cycle after fb_rd_en_o
//   pal_we_i         palette write strobe
//   pal_idx_i        palette write index
//   pal_data_i       palette write data {R,G,B}
//   rgb_o            pixel out {R,G,B}
//   hsync_out_o      hsync aligned with rgb_o
//   vsync_out_o      vsync aligned with rgb_o
//   de_out_o         display_on aligned with rgb_o
//   frame_cnt_o      frames since reset, 8-bit wrap
//   frame_start_o    one-cycle pulse after each frame boundary

module vga_pixel_stage #(
    parameter int H_DISPLAY   = 1024,
    parameter int V_DISPLAY   = 768,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 16,
    parameter int PIX_W       = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [10:0]       hpos_i,
    input  logic [9:0]        vpos_i,
    input  logic              display_on_i,
    input  logic              hsync_in_i,
    input  logic              vsync_in_i,
    input  logic [1:0]        mode_i,
    output logic              fb_rd_en_o,
    output logic [ADDR_W-1:0] fb_addr_o,
    input  logic [PIX_W-1:0]  fb_data_i,
    input  logic              pal_we_i,
    input  logic [3:0]        pal_idx_i,
    input  logic [11:0]       pal_data_i,
    output logic [11:0]       rgb_o,
    output logic              hsync_out_o,
    output logic              vsync_out_o,
    output logic              de_out_o,
    output logic [7:0]        frame_cnt_o,
    output logic              frame_start_o
);

    localparam int HB    = $clog2(H_DISPLAY);
    localparam int FB_HB = HB - SCALE_SHIFT;
    localparam int FB_VB = ADDR_W - FB_HB;

    localparam logic [1:0] MODE_FB     = 2'd0;
    localparam logic [1:0] MODE_BARS   = 2'd1;
    localparam logic [1:0] MODE_CHECK  = 2'd2;
    localparam logic [1:0] MODE_BORDER = 2'd3;

    // ------------------------------------------------------------------
    // Palette
    // ------------------------------------------------------------------
    logic [11:0] palette_q [16];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < 16; i++) begin
                palette_q[i] <= {4'(i), 4'(i), 4'(i)};
            end
        end else if (pal_we_i) begin
            palette_q[pal_idx_i] <= pal_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Frame boundary and mode latch
    // ------------------------------------------------------------------
    logic       boundary;
    logic [1:0] mode_q, mode_d;
    logic [1:0] mode_eff;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       frame_start_q, frame_start_d;

    assign boundary = (hpos_i == 11'd0) && (vpos_i == 10'd0);
    // The boundary pixel already belongs to the new frame, so it uses the
    // incoming mode rather than the one being replaced.
    assign mode_eff = boundary ? mode_i : mode_q;

    always_comb begin
        mode_d        = mode_q;
        frame_cnt_d   = frame_cnt_q;
        frame_start_d = 1'b0;
        if (boundary) begin
            mode_d        = mode_i;
            frame_cnt_d   = frame_cnt_q + 8'd1;
            frame_start_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mode_q        <= MODE_FB;
            frame_cnt_q   <= 8'd0;
            frame_start_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: framebuffer address, pattern colour, sync staging
    // ------------------------------------------------------------------
    logic              fb_rd_en_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic              fb_rd_en_q;
    logic [11:0]       pat_d;
    logic [11:0]       pat_s1_q, pat_s2_q;
    logic              is_fb_s1_q, is_fb_s2_q;
    logic [2:0]        bar;
    logic              border;

    assign bar    = hpos_i[HB-1 -: 3];
    assign border = (hpos_i == 11'd0) || (hpos_i == 11'(H_DISPLAY - 1)) ||
                    (vpos_i == 10'd0) || (vpos_i == 10'(V_DISPLAY - 1));

    always_comb begin
        fb_rd_en_d = display_on_i && (mode_eff == MODE_FB);
        fb_addr_d  = fb_addr_q;
        if (fb_rd_en_d) begin
            fb_addr_d = {vpos_i[SCALE_SHIFT +: FB_VB], hpos_i[SCALE_SHIFT +: FB_HB]};
        end
    end

    always_comb begin
        pat_d = 12'h000;
        case (mode_eff)
            MODE_BARS: begin
                case (bar)
                    3'd0:    pat_d = 12'hFFF;
                    3'd1:    pat_d = 12'hFF0;
                    3'd2:    pat_d = 12'h0FF;
                    3'd3:    pat_d = 12'h0F0;
                    3'd4:    pat_d = 12'hF0F;
                    3'd5:    pat_d = 12'hF00;
                    3'd6:    pat_d = 12'h00F;
                    default: pat_d = 12'h000;
                endcase
            end
            MODE_CHECK:  pat_d = (hpos_i[5] ^ vpos_i[5]) ? 12'hFFF : 12'h000;
            MODE_BORDER: pat_d = border ? 12'hFFF : palette_q[0];
            default:     pat_d = 12'h000;
        endcase
    end

    // ------------------------------------------------------------------
    // Sync/DE delay line: three flops, no gating, polarity untouched
    // ------------------------------------------------------------------
    logic [2:0] hs_q, vs_q, de_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hs_q <= 3'b000;
            vs_q <= 3'b000;
            de_q <= 3'b000;
        end else begin
            hs_q <= {hs_q[1:0], hsync_in_i};
            vs_q <= {vs_q[1:0], vsync_in_i};
            de_q <= {de_q[1:0], display_on_i};
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline registers (S1, S2, S3)
    // ------------------------------------------------------------------
    logic [11:0] rgb_q, rgb_d;

    // fb_data_i is the RAM's own registered output during S2, so the palette
    // lookup is taken straight off it into the S3 register.
    always_comb begin
        rgb_d = 12'h000;
        if (de_q[1]) begin
            rgb_d = is_fb_s2_q ? palette_q[fb_data_i] : pat_s2_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fb_rd_en_q <= 1'b0;
            fb_addr_q  <= '0;
            pat_s1_q   <= 12'h000;
            pat_s2_q   <= 12'h000;
            is_fb_s1_q <= 1'b0;
            is_fb_s2_q <= 1'b0;
            rgb_q      <= 12'h000;
        end else begin
            fb_rd_en_q <= fb_rd_en_d;
            fb_addr_q  <= fb_addr_d;
            pat_s1_q   <= pat_d;
            pat_s2_q   <= pat_s1_q;
            is_fb_s1_q <= (mode_eff == MODE_FB);
            is_fb_s2_q <= is_fb_s1_q;
            rgb_q      <= rgb_d;
        end
    end

    assign fb_rd_en_o    = fb_rd_en_q;
    assign fb_addr_o     = fb_addr_q;
    assign rgb_o         = rgb_q;
    assign hsync_out_o   = hs_q[2];
    assign vsync_out_o   = vs_q[2];
    assign de_out_o      = de_q[2];
    assign frame_cnt_o   = frame_cnt_q;
    assign frame_start_o = frame_start_q;

endmodule
